// File: rtl/fp32_to_dlfloat16.sv
// fp32_to_dlfloat16: two-stage FP32 -> DLFloat16 converter with valid/ready handshakes.
//   Stage 1 unpacks the FP32 operand, rebiases the exponent and rounds the mantissa to 9 bits.
//   Stage 2 classifies (special, zero, overflow, underflow, normal) and packs the result.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   in_valid/in_ready   input handshake; in_data (FP32) and rnd_mode (1 = truncate) go with it
//   out_valid/out_ready output handshake; out_data (DLFloat16), out_flags {nv, nx, of, uf, dz}
//   sticky_flags        OR of out_flags over transferred results; clr_flags clears it
module fp32_to_dlfloat16 #(
   parameter bit SATURATE = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_data,
   input  logic        rnd_mode,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [15:0] out_data,
   output logic [4:0]  out_flags,
   output logic [4:0]  sticky_flags,
   input  logic        clr_flags
);

   // ---------------- Stage 1: unpack and round ----------------
   logic [7:0]         e32;
   logic [22:0]        m32;
   logic               guard;
   logic               sticky;
   logic               round_up;
   logic [9:0]         mant_sum;
   logic signed [9:0]  e16_raw;

   logic               s1_valid_d, s1_valid_q;
   logic               s1_sign_d, s1_sign_q;
   logic signed [9:0]  s1_e16_d, s1_e16_q;
   logic [8:0]         s1_mant_d, s1_mant_q;
   logic               s1_inexact_d, s1_inexact_q;
   logic               s1_special_d, s1_special_q;  // e32 == 255
   logic               s1_zero_d, s1_zero_q;        // e32 == 0
   logic               s1_mnz_d, s1_mnz_q;          // m32 != 0

   logic               in_fire;
   logic               s2_adv;

   assign e32      = in_data[30:23];
   assign m32      = in_data[22:0];
   assign guard    = m32[13];
   assign sticky   = |m32[12:0];
   assign round_up = !rnd_mode & guard & (sticky | m32[14]);
   assign mant_sum = {1'b0, m32[22:14]} + {9'd0, round_up};
   assign e16_raw  = $signed({2'b00, e32}) - 10'sd96;

   // Stage 2 accepts new data when empty or when its current result leaves this cycle.
   assign s2_adv   = !out_valid | out_ready;
   assign in_ready = !s1_valid_q | s2_adv;
   assign in_fire  = in_valid & in_ready;

   always_comb begin
      s1_sign_d    = in_data[31];
      // A carry out of the mantissa leaves sum[8:0] == 0, which is the required mantissa.
      s1_mant_d    = mant_sum[8:0];
      s1_e16_d     = mant_sum[9] ? e16_raw + 10'sd1 : e16_raw;
      s1_inexact_d = guard | sticky;
      s1_special_d = (e32 == 8'hFF);
      s1_zero_d    = (e32 == 8'h00);
      s1_mnz_d     = (m32 != 23'd0);
      if (in_fire) begin
         s1_valid_d = 1'b1;
      end else if (s2_adv) begin
         s1_valid_d = 1'b0;
      end else begin
         s1_valid_d = s1_valid_q;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid_q   <= 1'b0;
         s1_sign_q    <= 1'b0;
         s1_e16_q     <= '0;
         s1_mant_q    <= '0;
         s1_inexact_q <= 1'b0;
         s1_special_q <= 1'b0;
         s1_zero_q    <= 1'b0;
         s1_mnz_q     <= 1'b0;
      end else begin
         s1_valid_q <= s1_valid_d;
         if (in_fire) begin
            s1_sign_q    <= s1_sign_d;
            s1_e16_q     <= s1_e16_d;
            s1_mant_q    <= s1_mant_d;
            s1_inexact_q <= s1_inexact_d;
            s1_special_q <= s1_special_d;
            s1_zero_q    <= s1_zero_d;
            s1_mnz_q     <= s1_mnz_d;
         end
      end
   end

   // ---------------- Stage 2: classify and pack ----------------
   logic [15:0] pk_data;
   logic [4:0]  pk_flags;
   logic [15:0] ovf_data;

   logic        out_valid_d, out_valid_q;
   logic [15:0] out_data_d, out_data_q;
   logic [4:0]  out_flags_d, out_flags_q;
   logic [4:0]  sticky_d, sticky_q;

   assign ovf_data = !SATURATE ? 16'hFFFF : (s1_sign_q ? 16'hFDFE : 16'h7DFE);

   always_comb begin
      pk_data  = {s1_sign_q, s1_e16_q[5:0], s1_mant_q};
      pk_flags = {1'b0, s1_inexact_q, 3'b000};
      if (s1_special_q) begin
         pk_data  = 16'hFFFF;
         pk_flags = s1_mnz_q ? 5'b10000 : 5'b00100;
      end else if (s1_zero_q) begin
         // FP32 zeros and subnormals both flush to the single unsigned zero code.
         pk_data  = 16'h0000;
         pk_flags = s1_mnz_q ? 5'b01010 : 5'b00000;
      end else if ((s1_e16_q >= 10'sd63) || ((s1_e16_q == 10'sd62) && (s1_mant_q == 9'h1FF))) begin
         // e16 == 62 with an all-ones mantissa would alias the 0x7DFF/0xFDFF codes.
         pk_data  = ovf_data;
         pk_flags = 5'b01100;
      end else if ((s1_e16_q <= 10'sd0) || ((s1_e16_q == 10'sd1) && (s1_mant_q == 9'h000))) begin
         pk_data  = s1_sign_q ? 16'h8201 : 16'h0201;
         pk_flags = 5'b01010;
      end
   end

   always_comb begin
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_flags_d = out_flags_q;
      if (s2_adv) begin
         out_valid_d = s1_valid_q;
         if (s1_valid_q) begin
            out_data_d  = pk_data;
            out_flags_d = pk_flags;
         end
      end
      // Clear wins over a same-cycle merge.
      if (clr_flags) begin
         sticky_d = 5'b00000;
      end else if (out_valid_q & out_ready) begin
         sticky_d = sticky_q | out_flags_q;
      end else begin
         sticky_d = sticky_q;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         out_data_q  <= 16'h0000;
         out_flags_q <= 5'b00000;
         sticky_q    <= 5'b00000;
      end else begin
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_flags_q <= out_flags_d;
         sticky_q    <= sticky_d;
      end
   end

   assign out_valid    = out_valid_q;
   assign out_data     = out_data_q;
   assign out_flags    = out_flags_q;
   assign sticky_flags = sticky_q;

endmodule

// File: tb/tb_fp32_to_dlfloat16.sv
// Bench for fp32_to_dlfloat16: directed vector table, backpressure, sticky flags, mid-stream
// reset and a randomized run checked against an arithmetic reference model via a scoreboard.
// Two instances share all inputs: one saturating, one returning 0xFFFF on overflow.
module tb_fp32_to_dlfloat16;

   typedef struct {
      logic [31:0] din;
      logic        rnd;
      logic [15:0] d;    // SATURATE = 1 result
      logic [15:0] dn;   // SATURATE = 0 result
      logic [4:0]  f;
   } vec_t;

   typedef struct {
      logic [15:0] d;
      logic [15:0] dn;
      logic [4:0]  f;
   } exp_t;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready, in_ready_ns;
   logic [31:0] in_data;
   logic        rnd_mode;
   logic        out_valid, out_valid_ns;
   logic        out_ready;
   logic [15:0] out_data, out_data_ns;
   logic [4:0]  out_flags, out_flags_ns;
   logic [4:0]  sticky_flags, sticky_flags_ns;
   logic        clr_flags;

   bit          clk_run = 1'b1;
   int          errors = 0;
   int          checks = 0;

   exp_t        exp_q[$];
   bit          use_table = 1'b0;
   vec_t        tab_exp;
   logic [4:0]  sticky_m = '0;
   bit          hold_pending = 1'b0;
   logic [15:0] hold_data;
   logic [4:0]  hold_flags;

   fp32_to_dlfloat16 #(.SATURATE(1'b1)) u_dut (
      .clk          (clk),
      .rst          (rst),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_data      (in_data),
      .rnd_mode     (rnd_mode),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_data     (out_data),
      .out_flags    (out_flags),
      .sticky_flags (sticky_flags),
      .clr_flags    (clr_flags)
   );

   fp32_to_dlfloat16 #(.SATURATE(1'b0)) u_dut_ns (
      .clk          (clk),
      .rst          (rst),
      .in_valid     (in_valid),
      .in_ready     (in_ready_ns),
      .in_data      (in_data),
      .rnd_mode     (rnd_mode),
      .out_valid    (out_valid_ns),
      .out_ready    (out_ready),
      .out_data     (out_data_ns),
      .out_flags    (out_flags_ns),
      .sticky_flags (sticky_flags_ns),
      .clr_flags    (clr_flags)
   );

   initial begin
      clk = 1'b0;
      forever begin
         #5;
         if (clk_run) clk = ~clk;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout, required completion");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, req);
      end
   endtask

   // Reference: value = 1.m32 * 2^(e32-127); keep 9 fraction bits, round on the dropped 14 bits.
   function automatic void model(input logic [31:0] x, input logic rnd, input bit sat,
                                 output logic [15:0] d, output logic [4:0] f);
      int e32  = int'(x[30:23]);
      int m    = int'(x[22:0]);
      bit s    = x[31];
      int q    = m / 16384;
      int rem  = m % 16384;
      int e    = e32 - 96;
      logic [5:0] eb;
      logic [8:0] qb;
      f = 5'b00000;
      if (e32 == 255) begin
         d = 16'hFFFF;
         f = (m != 0) ? 5'b10000 : 5'b00100;
         return;
      end
      if (e32 == 0) begin
         d = 16'h0000;
         f = (m != 0) ? 5'b01010 : 5'b00000;
         return;
      end
      if (rem != 0) f[3] = 1'b1;
      if (!rnd && (rem > 8192 || (rem == 8192 && (q % 2) == 1))) q++;
      if (q == 512) begin
         q = 0;
         e++;
      end
      if (e >= 63 || (e == 62 && q == 511)) begin
         f = 5'b01100;
         d = !sat ? 16'hFFFF : (s ? 16'hFDFE : 16'h7DFE);
         return;
      end
      if (e <= 0 || (e == 1 && q == 0)) begin
         f = 5'b01010;
         d = s ? 16'h8201 : 16'h0201;
         return;
      end
      eb = e[5:0];
      qb = q[8:0];
      d  = {s, eb, qb};
   endfunction

   // One clock cycle: observe handshakes on the falling edge, then let the rising edge act.
   task automatic step(output bit in_fire);
      exp_t e;
      logic [4:0] fdummy;
      @(negedge clk);
      in_fire = in_valid && in_ready;
      chk("sticky", {27'd0, sticky_flags}, {27'd0, sticky_m});
      chk("sticky_ns", {27'd0, sticky_flags_ns}, {27'd0, sticky_m});
      chk("valid_match", {31'd0, out_valid_ns}, {31'd0, out_valid});
      if (hold_pending) begin
         chk("hold_valid", {31'd0, out_valid}, 32'd1);
         chk("hold_data", {16'd0, out_data}, {16'd0, hold_data});
         chk("hold_flags", {27'd0, out_flags}, {27'd0, hold_flags});
      end
      if (out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            chk("spurious_out", {31'd0, out_valid}, 32'd0);
         end else begin
            e = exp_q.pop_front();
            chk("out_data", {16'd0, out_data}, {16'd0, e.d});
            chk("out_data_nosat", {16'd0, out_data_ns}, {16'd0, e.dn});
            chk("out_flags", {27'd0, out_flags}, {27'd0, e.f});
            chk("out_flags_nosat", {27'd0, out_flags_ns}, {27'd0, e.f});
            if (!clr_flags) sticky_m = sticky_m | e.f;
         end
      end
      if (clr_flags) sticky_m = 5'b00000;
      hold_pending = out_valid && !out_ready;
      hold_data    = out_data;
      hold_flags   = out_flags;
      if (in_fire) begin
         if (use_table) begin
            e.d  = tab_exp.d;
            e.dn = tab_exp.dn;
            e.f  = tab_exp.f;
         end else begin
            model(in_data, rnd_mode, 1'b1, e.d, e.f);
            model(in_data, rnd_mode, 1'b0, e.dn, fdummy);
         end
         exp_q.push_back(e);
      end
      @(posedge clk);
      #1;
   endtask

   // Single value through an idle pipe, with the latency checked on the way.
   task automatic run_vec(input vec_t v);
      bit f;
      use_table = 1'b1;
      tab_exp   = v;
      in_valid  = 1'b1;
      in_data   = v.din;
      rnd_mode  = v.rnd;
      out_ready = 1'b1;
      step(f);
      chk("accept", {31'd0, f}, 32'd1);
      in_valid = 1'b0;
      use_table = 1'b0;
      chk("lat_early", {31'd0, out_valid}, 32'd0);
      step(f);
      chk("lat_valid", {31'd0, out_valid}, 32'd1);
      step(f);
      chk("drained", exp_q.size(), 32'd0);
   endtask

   function automatic logic [31:0] rand_fp();
      logic [7:0]  e;
      logic [22:0] m;
      logic        s;
      int unsigned pick = $urandom_range(0, 15);
      case (pick)
         0:       e = 8'd0;
         1:       e = 8'd255;
         2:       e = 8'd95;
         3:       e = 8'd96;
         4:       e = 8'd97;
         5:       e = 8'd157;
         6:       e = 8'd158;
         7:       e = 8'd159;
         8:       e = 8'd127;
         9:       e = 8'd254;
         10:      e = 8'd1;
         default: e = 8'($urandom_range(0, 255));
      endcase
      m = 23'($urandom);
      if ($urandom_range(0, 3) == 0) m[12:0] = '0;
      if ($urandom_range(0, 3) == 0) m[22:14] = '1;
      if ($urandom_range(0, 7) == 0) m = '0;
      s = 1'($urandom_range(0, 1));
      return {s, e, m};
   endfunction

   vec_t vecs[16];
   logic [31:0] bp[4];

   initial begin
      bit f;
      int idx;
      int gaps;
      int bound;

      vecs[0]  = '{32'h3F800000, 1'b0, 16'h3E00, 16'h3E00, 5'b00000};
      vecs[1]  = '{32'hBF800000, 1'b0, 16'hBE00, 16'hBE00, 5'b00000};
      vecs[2]  = '{32'h00000000, 1'b0, 16'h0000, 16'h0000, 5'b00000};
      vecs[3]  = '{32'h80000000, 1'b0, 16'h0000, 16'h0000, 5'b00000};
      vecs[4]  = '{32'h3F802000, 1'b0, 16'h3E00, 16'h3E00, 5'b01000};
      vecs[5]  = '{32'h3F806000, 1'b0, 16'h3E02, 16'h3E02, 5'b01000};
      vecs[6]  = '{32'h3F806000, 1'b1, 16'h3E01, 16'h3E01, 5'b01000};
      vecs[7]  = '{32'h3FFFFFFF, 1'b0, 16'h4000, 16'h4000, 5'b01000};
      vecs[8]  = '{32'h7F000000, 1'b0, 16'h7DFE, 16'hFFFF, 5'b01100};
      vecs[9]  = '{32'hFF000000, 1'b0, 16'hFDFE, 16'hFFFF, 5'b01100};
      vecs[10] = '{32'h2F800000, 1'b0, 16'h0201, 16'h0201, 5'b01010};
      vecs[11] = '{32'h00000001, 1'b0, 16'h0000, 16'h0000, 5'b01010};
      vecs[12] = '{32'h80000001, 1'b0, 16'h0000, 16'h0000, 5'b01010};
      vecs[13] = '{32'hBF806000, 1'b1, 16'hBE01, 16'hBE01, 5'b01000};
      vecs[14] = '{32'h7FC00000, 1'b0, 16'hFFFF, 16'hFFFF, 5'b10000};
      vecs[15] = '{32'h7F800000, 1'b0, 16'hFFFF, 16'hFFFF, 5'b00100};
      bp[0] = 32'h3F800000;
      bp[1] = 32'h40000000;
      bp[2] = 32'h40400000;
      bp[3] = 32'hC0800000;

      rst       = 1'b1;
      in_valid  = 1'b0;
      in_data   = '0;
      rnd_mode  = 1'b0;
      out_ready = 1'b0;
      clr_flags = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_out_data", {16'd0, out_data}, 32'd0);
      chk("rst_out_flags", {27'd0, out_flags}, 32'd0);
      chk("rst_sticky", {27'd0, sticky_flags}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

      // Directed table
      for (int i = 0; i < 16; i++) run_vec(vecs[i]);

      // Sticky accumulation and clear
      clr_flags = 1'b1;
      step(f);
      clr_flags = 1'b0;
      run_vec(vecs[14]);
      run_vec(vecs[15]);
      chk("sticky_nan_inf", {27'd0, sticky_flags}, 32'b10100);
      clr_flags = 1'b1;
      step(f);
      clr_flags = 1'b0;
      chk("sticky_clr", {27'd0, sticky_flags}, 32'd0);

      // Clear coinciding with a flagged transfer
      use_table = 1'b1;
      tab_exp   = vecs[8];
      in_valid  = 1'b1;
      in_data   = vecs[8].din;
      rnd_mode  = 1'b0;
      out_ready = 1'b0;
      step(f);
      in_valid  = 1'b0;
      use_table = 1'b0;
      step(f);
      chk("clr_same_valid", {31'd0, out_valid}, 32'd1);
      clr_flags = 1'b1;
      out_ready = 1'b1;
      step(f);
      clr_flags = 1'b0;
      chk("clr_same_cycle", {27'd0, sticky_flags}, 32'd0);

      // Backpressure: four back-to-back offers into a stalled pipe
      out_ready = 1'b0;
      idx = 0;
      for (int c = 0; c < 4; c++) begin
         in_valid = 1'b1;
         in_data  = bp[idx];
         step(f);
         if (f) idx++;
      end
      chk("bp_accepted", idx, 32'd2);
      chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
      out_ready = 1'b1;
      gaps  = 0;
      bound = 0;
      while ((idx < 4 || exp_q.size() != 0) && bound < 20) begin
         in_valid = (idx < 4);
         in_data  = bp[idx % 4];
         if (!out_valid && exp_q.size() != 0) gaps++;
         step(f);
         if (f) idx++;
         bound++;
      end
      in_valid = 1'b0;
      chk("bp_all_accepted", idx, 32'd4);
      chk("bp_drained", exp_q.size(), 32'd0);
      chk("bp_no_gaps", gaps, 32'd0);

      // Reset with both stages full, clock stopped
      out_ready = 1'b0;
      for (int c = 0; c < 2; c++) begin
         in_valid = 1'b1;
         in_data  = bp[c];
         step(f);
      end
      in_valid = 1'b0;
      chk("full_out_valid", {31'd0, out_valid}, 32'd1);
      chk("full_in_ready", {31'd0, in_ready}, 32'd0);
      @(negedge clk);
      clk_run = 1'b0;
      #1;
      rst = 1'b1;
      #1;
      chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("midrst_out_data", {16'd0, out_data}, 32'd0);
      chk("midrst_sticky", {27'd0, sticky_flags}, 32'd0);
      #1;
      rst = 1'b0;
      exp_q.delete();
      hold_pending = 1'b0;
      sticky_m     = 5'b00000;
      clk_run      = 1'b1;
      @(posedge clk);
      #1;
      run_vec(vecs[5]);

      // Randomized traffic against the reference model
      for (int c = 0; c < 2000; c++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         in_data   = rand_fp();
         rnd_mode  = 1'($urandom_range(0, 1));
         out_ready = ($urandom_range(0, 3) != 0);
         clr_flags = ($urandom_range(0, 19) == 0);
         step(f);
      end
      in_valid  = 1'b0;
      clr_flags = 1'b0;
      out_ready = 1'b1;
      bound = 0;
      while (exp_q.size() != 0 && bound < 10) begin
         step(f);
         bound++;
      end
      chk("final_drain", exp_q.size(), 32'd0);
      step(f);
      chk("final_idle", {31'd0, out_valid}, 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
